lsu_mem_stage: RTL
==================

# lsu_mem_stage

Parametrised load/store unit for the MEM stage of the pipelined RV32I core, replacing fixed single-cycle data-memory access. It latches a memory op from EX/MEM and holds a request to data memory until `mem_resp`. It stalls the pipeline while the request is outstanding, generates byte enables and shifted store data, and returns sign- or zero-extended load data for MEM/WB. It supports 32- or 64-bit data paths, flags misaligned or illegal accesses, and handles flushes and reset while a request is in flight.

## Interface
- `DATA_WIDTH`, default 32. Memory data width; legal values are 32 and 64.
- `ADDR_WIDTH`, default 32. Byte address width.
- `BE_WIDTH`, default `DATA_WIDTH/8`. Derived parameter; must not be overridden.

- `clk`  in  1  — clock. One clock domain; reset is synchronous and active-high.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  1  — EX/MEM holds a memory op this cycle.
- `req_read`  in  1  — the op is a load.
- `req_write`  in  1  — the op is a store.
- `req_funct3`  in  3  — RISC-V load/store funct3.
- `req_addr`  in  `ADDR_WIDTH`  — effective byte address (ALU output).
- `req_wdata`  in  `DATA_WIDTH`  — store value (rs2, unshifted).
- `flush`  in  1  — squash the current or pending op.
- `stall_out`  out  1  — freeze PC and all pipeline registers.
- `mem_read`  out  1  — data-memory read request.
- `mem_write`  out  1  — data-memory write request.
- `mem_address`  out  `ADDR_WIDTH`  — address aligned down to `BE_WIDTH` bytes.
- `mem_wdata`  out  `DATA_WIDTH`  — store data shifted into its byte lanes.
- `mem_byte_enable`  out  `BE_WIDTH`  — active byte lanes.
- `mem_rdata`  in  `DATA_WIDTH`  — read data; valid while `mem_resp` is high.
- `mem_resp`  in  1  — memory completion, one-cycle pulse.
- `ld_data`  out  `DATA_WIDTH`  — extended load result.
- `ld_valid`  out  1  — `ld_data` valid, one-cycle pulse.
- `access_fault`  out  1  — misaligned or illegal op rejected, one-cycle pulse.

## Operation
- FSM has two states: IDLE and ACCESS.
- An op is accepted when: state is IDLE, `req_valid` is high, exactly one of `req_read`/`req_write` is high, `flush` is low, and the op is legal and aligned.
- On accept, latch address, funct3, direction and `req_wdata`, then go to ACCESS.
- Size by funct3:
  - 000/100 (lb/sb, lbu): 1 byte.
  - 001/101 (lh/sh, lhu): 2 bytes.
  - 010 (lw/sw): 4 bytes.
  - 110 (lwu): 4 bytes; load only, and only when `DATA_WIDTH`=64.
  - 011 (ld/sd): 8 bytes; only when `DATA_WIDTH`=64.
  - Any other funct3 is illegal.
- Alignment: `req_addr` must be a multiple of the access size. A halfword at offset 1 is misaligned.
- Fault: `req_valid`, a read or write, and the op is illegal, misaligned, or has both read and write high. Result: no accept, `access_fault` pulses next cycle, no stall, no memory request.
- `mem_byte_enable`: a contiguous mask of `size` ones shifted left by `addr mod BE_WIDTH`.
- `mem_wdata`: the low `size` bytes of wdata shifted left by `8*offset`; unused lanes are 0.
- Loads: select `size` bytes at the offset.
  - funct3 000/001/010/011 sign-extend to `DATA_WIDTH`.
  - funct3 100/101/110 zero-extend.
- In ACCESS:
  - `mem_read`/`mem_write` are driven high continuously, with address, data and byte enables stable, until the cycle `mem_resp` is high.
  - On `mem_resp`, return to IDLE.
  - For a load, register the extended `mem_rdata` into `ld_data` and pulse `ld_valid` next cycle.
- `stall_out` = (IDLE and accept) or (ACCESS and not `mem_resp`). Combinational.
- `mem_resp` in IDLE is ignored.
- Flush in ACCESS: the request cannot be aborted.
  - Memory outputs stay asserted until `mem_resp`.
  - Remember the flush; `ld_valid` is suppressed for this op.
  - `stall_out` is unchanged.
- Flush in IDLE blocks accept and `access_fault` for that cycle.

## Timing
- Reset values: state IDLE; all outputs 0 (`ld_data`=0, `mem_address`=0, `mem_byte_enable`=0).
- Reset during ACCESS: `mem_read`/`mem_write` are 0 in the cycle after `rst`; the pending response is discarded.
- Accept at cycle T: memory request visible from T+1.
- `mem_resp` at T+k (k≥1): `ld_valid`/`ld_data` at T+k+1.
- `stall_out` is high T..T+k-1, and low at T+k so that MEM/WB captures the op.
- Back-to-back ops: the next accept is allowed at T+k+1. Minimum 2 cycles per memory op.
- `ld_data` holds its value until the next load completes.
- `access_fault` and `ld_valid` are never high in the same cycle.

## Test plan
- lw at addr 0x100, `mem_resp` 3 cycles after request, `mem_rdata`=0xDEADBEEF:
  - `stall_out` high for 3 cycles, `mem_byte_enable`=1111, `mem_address`=0x100.
  - `ld_valid` with `ld_data`=0xDEADBEEF.
- lb at addr 0x103, `mem_rdata`=0x80FF_0000 with 1-cycle resp: `ld_data`=0xFFFFFF80. The same access as lbu gives `ld_data`=0x00000080.
- sh at addr 0x202, wdata=0x1234ABCD: `mem_address`=0x200, `mem_byte_enable`=1100, `mem_wdata`=0xABCD0000.
- lh at 0x201, and lw at 0x102: `access_fault` pulses, `mem_read` stays 0, `stall_out` stays 0.
- lw accepted, `flush` in the first ACCESS cycle, resp after 2 cycles: the request stays asserted until resp, and `ld_valid` is never asserted.
- `DATA_WIDTH`=64, ld at 0x8, `mem_rdata`=0x8000_0000_0000_0001: `mem_byte_enable`=0xFF, `ld_data`=0x8000_0000_0000_0001.
- `rst` in the middle of ACCESS: `mem_read` drops the next cycle.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: holds one request to data memory until mem_resp,
// stalls the pipeline meanwhile, and lane-aligns store data and load results.
module lsu_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  flush,
  output logic                  stall_out,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [BE_WIDTH-1:0]   mem_byte_enable,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_valid,
  output logic                  access_fault
);

  localparam int OFF_W = $clog2(BE_WIDTH);

  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_next;

  logic [3:0]            req_size;
  logic                  req_legal;
  logic                  req_aligned;
  logic [OFF_W-1:0]      req_off;
  logic                  req_ok;
  logic                  accept;
  logic                  fault;
  logic [BE_WIDTH-1:0]   be_next;
  logic [DATA_WIDTH-1:0] wdata_next;

  logic [OFF_W-1:0]      off_q;
  logic [3:0]            size_q;
  logic                  sext_q;
  logic                  is_read_q;
  logic                  flushed_q;
  logic [DATA_WIDTH-1:0] rdata_shifted;
  logic                  sign_bit;
  logic [DATA_WIDTH-1:0] ld_ext;

  assign req_off = req_addr[OFF_W-1:0];

  always_comb begin
    req_size  = 4'd1;
    req_legal = 1'b1;
    case (req_funct3)
      3'b000, 3'b100: req_size = 4'd1;
      3'b001, 3'b101: req_size = 4'd2;
      3'b010:         req_size = 4'd4;
      3'b110: begin
        req_size  = 4'd4;
        req_legal = req_read && !req_write && (DATA_WIDTH == 64);
      end
      3'b011: begin
        req_size  = 4'd8;
        req_legal = (DATA_WIDTH == 64);
      end
      default: req_legal = 1'b0;
    endcase
  end

  assign req_aligned = (req_off & OFF_W'(req_size - 4'd1)) == '0;

  // Only IDLE evaluates new ops; while busy EX/MEM is frozen on the same op.
  assign req_ok = req_valid && (state == IDLE) && !flush && (req_read || req_write);
  assign accept = req_ok && (req_read ^ req_write) && req_legal && req_aligned;
  assign fault  = req_ok && !((req_read ^ req_write) && req_legal && req_aligned);

  always_comb begin
    be_next    = '0;
    wdata_next = '0;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (i >= int'(req_off) && i < int'(req_off) + int'(req_size)) be_next[i] = 1'b1;
      if (i < int'(req_size)) wdata_next[8*i +: 8] = req_wdata[8*i +: 8];
    end
    wdata_next = wdata_next << {req_off, 3'b000};
  end

  // Bring the addressed bytes down to lane 0, then fill above with sign or zero.
  always_comb begin
    rdata_shifted = mem_rdata >> {off_q, 3'b000};
    sign_bit      = 1'b0;
    ld_ext        = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i == 8 * int'(size_q) - 1) sign_bit = rdata_shifted[i];
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      ld_ext[i] = (i < 8 * int'(size_q)) ? rdata_shifted[i] : (sext_q & sign_bit);
    end
  end

  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ACCESS;
          stall_out  = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_resp) state_next = IDLE;
        else          stall_out  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_read  = (state == ACCESS) && is_read_q;
  assign mem_write = (state == ACCESS) && !is_read_q;

  // A flush seen during ACCESS cannot cancel the bus request, only its writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      off_q           <= '0;
      size_q          <= 4'd0;
      sext_q          <= 1'b0;
      is_read_q       <= 1'b0;
      flushed_q       <= 1'b0;
      ld_data         <= '0;
      ld_valid        <= 1'b0;
      access_fault    <= 1'b0;
    end else begin
      state        <= state_next;
      access_fault <= fault;
      ld_valid     <= 1'b0;
      if (accept) begin
        mem_address     <= {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        mem_byte_enable <= be_next;
        mem_wdata       <= req_write ? wdata_next : '0;
        off_q           <= req_off;
        size_q          <= req_size;
        sext_q          <= !req_funct3[2];
        is_read_q       <= req_read;
        flushed_q       <= 1'b0;
      end
      if (state == ACCESS) begin
        if (flush) flushed_q <= 1'b1;
        if (mem_resp && is_read_q && !flushed_q && !flush) begin
          ld_data  <= ld_ext;
          ld_valid <= 1'b1;
        end
      end
    end
  end

endmodule
